// File: rtl/pc_call_stack_pkg.sv
// rtl/pc_call_stack_pkg.sv - shared constants and jump-condition helper for the pc stage and control unit
// Contents:
//   PC_ADDR_W, PC_STACK_DEPTH, PC_SP_W : default geometry
//   J_ALWAYS/J_ZERO/J_CARRY/J_NZERO    : j_mode encodings shared with the control unit
//   jump_taken()                       : evaluates a j_mode against the ALU status flags
package pc_call_stack_pkg;

    localparam int PC_ADDR_W      = 10;
    localparam int PC_STACK_DEPTH = 8;
    localparam int PC_SP_W        = 3;

    localparam logic [1:0] J_ALWAYS = 2'b00;
    localparam logic [1:0] J_ZERO   = 2'b01;
    localparam logic [1:0] J_CARRY  = 2'b10;
    localparam logic [1:0] J_NZERO  = 2'b11;

    function automatic logic jump_taken(input logic [1:0] mode, input logic z, input logic c);
        logic t;
        t = 1'b1;
        case (mode)
            J_ALWAYS: t = 1'b1;
            J_ZERO:   t = z;
            J_CARRY:  t = c;
            J_NZERO:  t = ~z;
            default:  t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// rtl/pc_call_stack_if.sv - flow-control bus between control unit (master) and pc stage (slave)
// Signals:
//   en, jump, j_mode, call, ret, target, zero_flag, carry_flag : master -> slave
//   pc, sp, stack_ovf, stack_unf                               : slave -> master
// ret carries the control unit's return request (return is a reserved word).
interface pc_call_stack_if #(
    parameter int ADDR_W = 10,
    parameter int SP_W   = 3
);
    logic              en;
    logic              jump;
    logic [1:0]        j_mode;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] target;
    logic              zero_flag;
    logic              carry_flag;
    logic [ADDR_W-1:0] pc;
    logic [SP_W:0]     sp;
    logic              stack_ovf;
    logic              stack_unf;

    modport master (
        output en, jump, j_mode, call, ret, target, zero_flag, carry_flag,
        input  pc, sp, stack_ovf, stack_unf
    );

    modport slave (
        input  en, jump, j_mode, call, ret, target, zero_flag, carry_flag,
        output pc, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_call_stack_call_stack.sv
// rtl/pc_call_stack_call_stack.sv - LIFO return-address stack, DEPTH x ADDR_W
// Ports:
//   clk, rst_n : clock, async active-low reset (occupancy only; entries are don't-care)
//   push, pop  : push push_data / discard top; ignored when full / empty respectively
//   push_data  : value to push
//   top        : entry at sp-1 (meaningless when empty)
//   sp         : occupancy 0..DEPTH
//   full, empty: occupancy flags
module pc_call_stack_call_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 8,
    parameter int SP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [SP_W:0]     sp,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [SP_W:0]     count;
    logic [SP_W:0]     count_m1;

    assign count_m1 = count - (SP_W+1)'(1);
    assign full     = (count == (SP_W+1)'(DEPTH));
    assign empty    = (count == '0);
    // DEPTH is a power of two, so the low SP_W bits address every entry.
    assign top      = mem[count_m1[SP_W-1:0]];
    assign sp       = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + (SP_W+1)'(1);
        end else if (pop && !empty) begin
            count <= count_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[SP_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with conditional jump and hardware call/return stack
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : pc_call_stack_if.slave - en/jump/j_mode/call/ret/target/flags in; pc/sp/stack_ovf/stack_unf out
// One action per enabled cycle, priority return > call > jump > sequential.
module pc_call_stack
    import pc_call_stack_pkg::*;
#(
    parameter int ADDR_W      = PC_ADDR_W,
    parameter int STACK_DEPTH = PC_STACK_DEPTH,
    parameter int SP_W        = PC_SP_W
) (
    input  logic clk,
    input  logic rst_n,
    pc_call_stack_if.slave bus
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] stack_top;
    logic [SP_W:0]     stack_sp;
    logic              stack_full;
    logic              stack_empty;
    logic              push;
    logic              pop;
    logic              taken;
    logic              ovf_q;
    logic              unf_q;

    // Wraps modulo 2^ADDR_W; the same value is what a call pushes.
    assign pc_inc = pc_q + ADDR_W'(1);
    assign taken  = jump_taken(bus.j_mode, bus.zero_flag, bus.carry_flag);

    // A simultaneous return suppresses the call entirely, including its push.
    assign push = bus.en && !bus.ret && bus.call && !stack_full;
    assign pop  = bus.en && bus.ret && !stack_empty;

    pc_call_stack_call_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .SP_W   (SP_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .sp        (stack_sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // Failed returns/calls fall through to sequential execution.
    always_comb begin
        next_pc = pc_inc;
        if (bus.ret) begin
            if (!stack_empty) begin
                next_pc = stack_top;
            end
        end else if (bus.call) begin
            if (!stack_full) begin
                next_pc = bus.target;
            end
        end else if (bus.jump && taken) begin
            next_pc = bus.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (bus.en) begin
            pc_q <= next_pc;
            if (bus.ret && stack_empty) begin
                unf_q <= 1'b1;
            end
            if (!bus.ret && bus.call && stack_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.sp        = stack_sp;
    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;

endmodule
